// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
//   Shared definitions for the accumulator-machine control unit: opcode width,
//   FSM state encodings, opcode constants, bus-index and ALU-op constants, and
//   the decoded-instruction record passed from ctrl_decode to the sequencer.
//   Optional feature macro (consumed by ctrl_decode): CTRL_COND_BRANCH_EN.
package cpu_ctrl_pkg;

   localparam int OPC_W = 5;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_F0   = 4'd1,
      ST_F1   = 4'd2,
      ST_F2   = 4'd3,
      ST_D    = 4'd4,
      ST_EX   = 4'd5,
      ST_M0   = 4'd6,
      ST_M1   = 4'd7,
      ST_M2   = 4'd8,
      ST_HALT = 4'd9
   } state_t;

   // Opcodes
   localparam logic [OPC_W-1:0] OP_NOP    = 5'h00;
   localparam logic [OPC_W-1:0] OP_HALT   = 5'h01;
   localparam logic [OPC_W-1:0] OP_LD     = 5'h02;
   localparam logic [OPC_W-1:0] OP_ST     = 5'h03;
   localparam logic [OPC_W-1:0] OP_MOVA   = 5'h04;
   localparam logic [OPC_W-1:0] OP_MOVT   = 5'h05;
   localparam logic [OPC_W-1:0] OP_INCD   = 5'h06;
   localparam logic [OPC_W-1:0] OP_ALU_LO = 5'h08;
   localparam logic [OPC_W-1:0] OP_ALU_HI = 5'h0E;
   localparam logic [OPC_W-1:0] OP_SHL_LO = 5'h10;
   localparam logic [OPC_W-1:0] OP_SHL_HI = 5'h13;
   localparam logic [OPC_W-1:0] OP_JMP    = 5'h18;
   localparam logic [OPC_W-1:0] OP_JZ     = 5'h19;
   localparam logic [OPC_W-1:0] OP_JC     = 5'h1A;
   localparam logic [OPC_W-1:0] OP_JN     = 5'h1B;

   // Register-bank / bus indices (MDR is a bus-B source only)
   localparam logic [2:0] BUS_PC   = 3'd0;
   localparam logic [2:0] BUS_DPTR = 3'd1;
   localparam logic [2:0] BUS_A    = 3'd2;
   localparam logic [2:0] BUS_TEMP = 3'd3;
   localparam logic [2:0] BUS_ACC  = 3'd4;
   localparam logic [2:0] BUS_MDR  = 3'd5;

   // ALU operations
   localparam logic [2:0] ALU_PASSB = 3'b000;
   localparam logic [2:0] ALU_INC   = 3'b001;
   localparam logic [2:0] ALU_ADD   = 3'b010;
   localparam logic [2:0] ALU_SUB   = 3'b011;
   localparam logic [2:0] ALU_AND   = 3'b100;
   localparam logic [2:0] ALU_OR    = 3'b101;
   localparam logic [2:0] ALU_XOR   = 3'b110;
   localparam logic [2:0] ALU_SHL   = 3'b111;

   // Instruction class; SKIP is a not-taken conditional branch.
   typedef enum logic [2:0] {
      CLS_NONE, CLS_EX, CLS_LD, CLS_ST, CLS_JMP, CLS_SKIP
   } cls_t;

   // Fields the sequencer keeps after the decode cycle.
   typedef struct packed {
      cls_t       cls;
      logic [2:0] selop;
      logic [1:0] shamt;
      logic [2:0] bus_b;
      logic [2:0] bus_c;
      logic       enaf;
   } ex_t;

   typedef struct packed {
      ex_t    ex;
      state_t nxt;       // state to enter after D
      logic   illegal;   // undefined opcode
   } dec_t;

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if
//   Control/status bundle between control_sequencer (master) and memory_system
//   (slave): instruction and ALU flags in, every datapath strobe and select out.
interface control_sequencer_if;
   import cpu_ctrl_pkg::*;

   logic [OPC_W-1:0] instruction;
   logic             C, N, P, Z;
   logic             ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en;
   logic             wr_rdn, mdr_alu_n, mdr_en;
   logic [2:0]       selop;
   logic [1:0]       shamt;
   logic [2:0]       busB_addr, busC_addr;

   modport master (
      input  instruction, C, N, P, Z,
      output ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en,
             wr_rdn, mdr_alu_n, mdr_en, selop, shamt, busB_addr, busC_addr
   );

   modport slave (
      output instruction, C, N, P, Z,
      input  ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en,
             wr_rdn, mdr_alu_n, mdr_en, selop, shamt, busB_addr, busC_addr
   );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode
//   Combinational opcode decoder: opcode + flags -> class, ALU op, shift
//   amount, bus selects, flag enable, next state after D, illegal.
//   Ports: opcode (in, OPC_W), c/n/z (in, flags), dec (out, dec_t).
//   Macro CTRL_COND_BRANCH_EN: when defined 19/1A/1B decode as JZ/JC/JN,
//   otherwise they are undefined opcodes.
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   input  logic             c,
   input  logic             n,
   input  logic             z,
   output dec_t             dec
);

   // NOTE: every output gets a default before the case so no path leaves a
   // field unassigned, which would infer a latch.
   always_comb begin
      dec        = '0;
      dec.nxt    = ST_F0;
      dec.ex.cls = CLS_NONE;
      case (opcode) inside
         OP_NOP:  dec.nxt = ST_F0;
         OP_HALT: dec.nxt = ST_HALT;
         OP_LD: begin
            dec.ex.cls = CLS_LD;
            dec.nxt    = ST_M0;
         end
         OP_ST: begin
            dec.ex.cls = CLS_ST;
            dec.nxt    = ST_M0;
         end
         OP_MOVA, OP_MOVT: begin
            dec.ex.cls   = CLS_EX;
            dec.ex.bus_b = BUS_ACC;
            dec.ex.bus_c = (opcode == OP_MOVA) ? BUS_A : BUS_TEMP;
            dec.nxt      = ST_EX;
         end
         OP_INCD: begin
            dec.ex.cls   = CLS_EX;
            dec.ex.bus_b = BUS_DPTR;
            dec.ex.selop = ALU_INC;
            dec.ex.bus_c = BUS_DPTR;
            dec.nxt      = ST_EX;
         end
         [OP_ALU_LO:OP_ALU_HI]: begin
            // A is the ALU's fixed left operand; TEMP arrives on bus B.
            dec.ex.cls   = CLS_EX;
            dec.ex.bus_b = BUS_TEMP;
            dec.ex.selop = opcode[2:0];
            dec.ex.bus_c = BUS_ACC;
            dec.ex.enaf  = 1'b1;
            dec.nxt      = ST_EX;
         end
         [OP_SHL_LO:OP_SHL_HI]: begin
            dec.ex.cls   = CLS_EX;
            dec.ex.bus_b = BUS_ACC;
            dec.ex.selop = ALU_SHL;
            dec.ex.shamt = opcode[1:0];
            dec.ex.bus_c = BUS_ACC;
            dec.ex.enaf  = 1'b1;
            dec.nxt      = ST_EX;
         end
         OP_JMP: begin
            dec.ex.cls = CLS_JMP;
            dec.nxt    = ST_M0;
         end
`ifdef CTRL_COND_BRANCH_EN
         // Flags are sampled here, in the D cycle; a not-taken branch only
         // steps PC past its operand byte.
         OP_JZ: begin
            dec.ex.cls = z ? CLS_JMP : CLS_SKIP;
            dec.nxt    = ST_M0;
         end
         OP_JC: begin
            dec.ex.cls = c ? CLS_JMP : CLS_SKIP;
            dec.nxt    = ST_M0;
         end
         OP_JN: begin
            dec.ex.cls = n ? CLS_JMP : CLS_SKIP;
            dec.nxt    = ST_M0;
         end
`else
         OP_JZ, OP_JC, OP_JN: begin
            dec.illegal = 1'b1;
            dec.nxt     = ST_HALT;
         end
`endif
         default: begin
            dec.illegal = 1'b1;
            dec.nxt     = ST_HALT;
         end
      endcase
   end

`ifndef CTRL_COND_BRANCH_EN
   logic unused_flags;
   assign unused_flags = c ^ n ^ z;
`endif

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//   Fetch/decode/execute sequencer for the 8-bit accumulator machine. Drives
//   every memory_system control from the current state plus the instruction
//   fields latched in the decode cycle (Moore outputs).
//   Ports: clk, rst (async, active high), run (start from IDLE),
//          bus (control_sequencer_if.master: instruction/flags in, strobes out),
//          halted (IDLE or HALT), illegal (sticky undefined-opcode flag),
//          state_dbg (current state encoding).
//   Macro CTRL_COND_BRANCH_EN enables JZ/JC/JN (see ctrl_decode).
module control_sequencer
   import cpu_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   control_sequencer_if.master bus,
   output logic                halted,
   output logic                illegal,
   output logic [3:0]          state_dbg
);

   state_t state, state_nxt;
   dec_t   dec;
   ex_t    ex_q;
   logic   unused_p;

   ctrl_decode u_decode (
      .opcode (bus.instruction),
      .c      (bus.C),
      .n      (bus.N),
      .z      (bus.Z),
      .dec    (dec)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         ex_q    <= '0;
         illegal <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_D) begin
            ex_q <= dec.ex;
            if (dec.illegal) illegal <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (run) state_nxt = ST_F0;
         ST_F0:   state_nxt = ST_F1;
         ST_F1:   state_nxt = ST_F2;
         ST_F2:   state_nxt = ST_D;
         ST_D:    state_nxt = dec.nxt;
         ST_EX:   state_nxt = ST_F0;
         ST_M0:   state_nxt = (ex_q.cls == CLS_SKIP) ? ST_F0 : ST_M1;
         ST_M1:   state_nxt = ST_M2;
         ST_M2:   state_nxt = ST_F0;
         ST_HALT: state_nxt = ST_HALT;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.ir_sclr    = 1'b0;
      bus.mar_sclr   = 1'b0;
      bus.enaf       = 1'b0;
      bus.bank_wr_en = 1'b0;
      bus.ir_en      = 1'b0;
      bus.mar_en     = 1'b0;
      bus.wr_rdn     = 1'b0;
      bus.mdr_alu_n  = 1'b0;
      bus.mdr_en     = 1'b0;
      bus.selop      = ALU_PASSB;
      bus.shamt      = 2'd0;
      bus.busB_addr  = BUS_PC;
      bus.busC_addr  = BUS_PC;
      case (state)
         ST_IDLE: begin
            bus.ir_sclr  = 1'b1;
            bus.mar_sclr = 1'b1;
         end
         ST_F0: bus.mar_en = 1'b1;                  // MAR <= PC
         ST_F1: begin                               // MDR <= mem, PC <= PC+1
            bus.mdr_alu_n  = 1'b1;
            bus.mdr_en     = 1'b1;
            bus.selop      = ALU_INC;
            bus.bank_wr_en = 1'b1;
         end
         ST_F2: begin                               // IR <= MDR
            bus.busB_addr = BUS_MDR;
            bus.ir_en     = 1'b1;
         end
         ST_EX: begin
            bus.busB_addr  = ex_q.bus_b;
            bus.selop      = ex_q.selop;
            bus.shamt      = ex_q.shamt;
            bus.busC_addr  = ex_q.bus_c;
            bus.enaf       = ex_q.enaf;
            bus.bank_wr_en = 1'b1;
         end
         ST_M0: begin
            case (ex_q.cls)
               CLS_LD, CLS_ST: begin
                  bus.busB_addr = BUS_DPTR;
                  bus.mar_en    = 1'b1;
               end
               CLS_JMP: bus.mar_en = 1'b1;          // MAR <= PC (operand)
               CLS_SKIP: begin                      // step over operand
                  bus.selop      = ALU_INC;
                  bus.bank_wr_en = 1'b1;
               end
               default: ;
            endcase
         end
         ST_M1: begin
            case (ex_q.cls)
               CLS_LD: begin
                  bus.mdr_alu_n = 1'b1;
                  bus.mdr_en    = 1'b1;
               end
               CLS_ST: begin                        // MDR <= ACC via ALU
                  bus.busB_addr = BUS_ACC;
                  bus.mdr_en    = 1'b1;
               end
               CLS_JMP: begin
                  bus.mdr_alu_n  = 1'b1;
                  bus.mdr_en     = 1'b1;
                  bus.selop      = ALU_INC;
                  bus.bank_wr_en = 1'b1;
               end
               default: ;
            endcase
         end
         ST_M2: begin
            case (ex_q.cls)
               CLS_LD: begin
                  bus.busB_addr  = BUS_MDR;
                  bus.busC_addr  = BUS_ACC;
                  bus.bank_wr_en = 1'b1;
               end
               CLS_ST: bus.wr_rdn = 1'b1;
               CLS_JMP: begin
                  bus.busB_addr  = BUS_MDR;
                  bus.bank_wr_en = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign halted    = (state == ST_IDLE) || (state == ST_HALT);
   assign state_dbg = state;
   assign unused_p  = bus.P;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Runs control_sequencer against a small behavioural memory_system model
//   (bank PC/DPTR/A/TEMP/ACC, MAR, MDR, IR, flags, 256-byte memory). ALU left
//   operand is A, right operand is bus B. Each directed program pushes its
//   expected end state; a monitor pops and compares when halted rises.
module tb_control_sequencer;
   import cpu_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic       halted, illegal;
   logic [3:0] state_dbg;

   control_sequencer_if bus ();

   control_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .bus       (bus),
      .halted    (halted),
      .illegal   (illegal),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   // ---------------- memory_system model ----------------
   logic [7:0] mem [256];
   logic [7:0] pc, dptr, a, temp, acc, mdr, mar, ir;
   logic       fc, fn, fp, fz;
   logic       pre_mem_we = 1'b0, pre_reg_we = 1'b0;
   logic [7:0] pre_addr = '0, pre_data = '0;
   logic [2:0] pre_idx = '0;
   logic [7:0] bv;
   logic [8:0] res;

   always_comb begin
      case (bus.busB_addr)
         BUS_PC:   bv = pc;
         BUS_DPTR: bv = dptr;
         BUS_A:    bv = a;
         BUS_TEMP: bv = temp;
         BUS_ACC:  bv = acc;
         BUS_MDR:  bv = mdr;
         default:  bv = 8'h00;
      endcase
      case (bus.selop)
         ALU_PASSB: res = {1'b0, bv};
         ALU_INC:   res = {1'b0, bv} + 9'd1;
         ALU_ADD:   res = {1'b0, a} + {1'b0, bv};
         ALU_SUB:   res = {1'b0, a} - {1'b0, bv};
         ALU_AND:   res = {1'b0, a & bv};
         ALU_OR:    res = {1'b0, a | bv};
         ALU_XOR:   res = {1'b0, a ^ bv};
         default:   res = {1'b0, bv} << bus.shamt;
      endcase
   end

   always @(posedge clk) begin
      if (pre_mem_we) mem[pre_addr] <= pre_data;
      if (pre_reg_we) begin
         case (pre_idx)
            BUS_PC:   pc   <= pre_data;
            BUS_DPTR: dptr <= pre_data;
            BUS_A:    a    <= pre_data;
            BUS_TEMP: temp <= pre_data;
            BUS_ACC:  acc  <= pre_data;
            default: ;
         endcase
      end
      if (bus.bank_wr_en) begin
         case (bus.busC_addr)
            BUS_PC:   pc   <= res[7:0];
            BUS_DPTR: dptr <= res[7:0];
            BUS_A:    a    <= res[7:0];
            BUS_TEMP: temp <= res[7:0];
            BUS_ACC:  acc  <= res[7:0];
            default: ;
         endcase
      end
      if (bus.mar_sclr)    mar <= 8'h00;
      else if (bus.mar_en) mar <= res[7:0];
      if (bus.mdr_en) mdr <= bus.mdr_alu_n ? mem[mar] : res[7:0];
      if (bus.wr_rdn) mem[mar] <= mdr;
      if (bus.ir_sclr)    ir <= 8'h00;
      else if (bus.ir_en) ir <= mdr;
      if (bus.enaf) begin
         fc <= res[8];
         fz <= (res[7:0] == 8'h00);
         fn <= res[7];
         fp <= ~^res[7:0];
      end
   end

   assign bus.instruction = ir[4:0];
   assign bus.C = fc;
   assign bus.N = fn;
   assign bus.P = fp;
   assign bus.Z = fz;

   // ---------------- scoreboard ----------------
   typedef struct {
      string      name;
      int         cycles;
      logic [7:0] pc;
      logic       ill;
      logic       chk_acc;
      logic [7:0] acc;
      logic       chk_z;
      logic       z;
      logic       chk_mem;
      logic [7:0] mem_addr;
      logic [7:0] mem_val;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   done_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: counts busy cycles; compares end state when halted rises.
   initial begin
      logic halted_d;
      int   busy;
      exp_t e;
      halted_d = 1'b1;
      busy     = 0;
      forever begin
         @(negedge clk);
         if (!halted) busy++;
         else begin
            if (!halted_d && !rst) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_halt: state %0d with no program pending", state_dbg);
               end else begin
                  e = exp_q.pop_front();
                  check({e.name, ".cycles"}, busy, e.cycles);
                  check({e.name, ".pc"}, pc, e.pc);
                  check({e.name, ".illegal"}, illegal, e.ill);
                  check({e.name, ".state"}, state_dbg, ST_HALT);
                  if (e.chk_acc) check({e.name, ".acc"}, acc, e.acc);
                  if (e.chk_z)   check({e.name, ".z"}, fz, e.z);
                  if (e.chk_mem) check({e.name, ".mem"}, mem[e.mem_addr], e.mem_val);
               end
               done_cnt++;
            end
            busy = 0;
         end
         halted_d = halted;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_mem(input logic [7:0] addr, input logic [7:0] data);
      pre_mem_we = 1'b1; pre_addr = addr; pre_data = data;
      @(negedge clk);
      pre_mem_we = 1'b0;
   endtask

   task automatic set_reg(input logic [2:0] idx, input logic [7:0] data);
      pre_reg_we = 1'b1; pre_idx = idx; pre_data = data;
      @(negedge clk);
      pre_reg_we = 1'b0;
   endtask

   task automatic begin_test();
      rst = 1'b1;
      @(negedge clk);
      set_reg(BUS_PC, 8'h00);
   endtask

   function automatic exp_t mk(input string name, input int cycles, input logic [7:0] epc,
                               input logic ill);
      exp_t e;
      e.name = name; e.cycles = cycles; e.pc = epc; e.ill = ill;
      e.chk_acc = 1'b0; e.acc = '0; e.chk_z = 1'b0; e.z = 1'b0;
      e.chk_mem = 1'b0; e.mem_addr = '0; e.mem_val = '0;
      return e;
   endfunction

   task automatic go(input exp_t e);
      int start;
      int n;
      rst = 1'b0;
      @(negedge clk);
      exp_q.push_back(e);
      start = done_cnt;
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      n = 0;
      while (done_cnt == start && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt == start) begin
         checks++;
         failures++;
         $display("FAIL %s.timeout: no halt after %0d cycles, state %0d", e.name, n, state_dbg);
         exp_q.delete();
      end
   endtask

   // ---------------- tests ----------------
   initial begin
      exp_t e;
      int   n;

      #20;
      check("rst.halted",     halted,         1'b1);
      check("rst.ir_sclr",    bus.ir_sclr,    1'b1);
      check("rst.mar_sclr",   bus.mar_sclr,   1'b1);
      check("rst.bank_wr_en", bus.bank_wr_en, 1'b0);
      check("rst.wr_rdn",     bus.wr_rdn,     1'b0);
      check("rst.mdr_en",     bus.mdr_en,     1'b0);
      check("rst.state",      state_dbg,      ST_IDLE);
      check("rst.illegal",    illegal,        1'b0);

      // NOP; HALT
      begin_test();
      set_mem(8'h00, 8'h00); set_mem(8'h01, 8'h01);
      go(mk("nop", 8, 8'h02, 1'b0));

      // ADD 5+3
      begin_test();
      set_reg(BUS_A, 8'h05); set_reg(BUS_TEMP, 8'h03);
      set_mem(8'h00, 8'h0A); set_mem(8'h01, 8'h01);
      e = mk("add", 9, 8'h02, 1'b0);
      e.chk_acc = 1'b1; e.acc = 8'h08; e.chk_z = 1'b1; e.z = 1'b0;
      go(e);

      // SUB equal operands
      begin_test();
      set_reg(BUS_A, 8'h07); set_reg(BUS_TEMP, 8'h07);
      set_mem(8'h00, 8'h0B); set_mem(8'h01, 8'h01);
      e = mk("sub", 9, 8'h02, 1'b0);
      e.chk_acc = 1'b1; e.acc = 8'h00; e.chk_z = 1'b1; e.z = 1'b1;
      go(e);

      // SUB (Z=1); LD; INC DPTR; ST; HALT -- flags must survive LD/INC/ST
      begin_test();
      set_reg(BUS_A, 8'h07); set_reg(BUS_TEMP, 8'h07); set_reg(BUS_DPTR, 8'h20);
      set_mem(8'h20, 8'h5A); set_mem(8'h21, 8'h00);
      set_mem(8'h00, 8'h0B); set_mem(8'h01, 8'h02); set_mem(8'h02, 8'h06);
      set_mem(8'h03, 8'h03); set_mem(8'h04, 8'h01);
      e = mk("ldst", 28, 8'h05, 1'b0);
      e.chk_acc = 1'b1; e.acc = 8'h5A; e.chk_z = 1'b1; e.z = 1'b1;
      e.chk_mem = 1'b1; e.mem_addr = 8'h21; e.mem_val = 8'h5A;
      go(e);

      // SHL by 2
      begin_test();
      set_reg(BUS_ACC, 8'h03);
      set_mem(8'h00, 8'h12); set_mem(8'h01, 8'h01);
      e = mk("shl", 9, 8'h02, 1'b0);
      e.chk_acc = 1'b1; e.acc = 8'h0C; e.chk_z = 1'b1; e.z = 1'b0;
      go(e);

      // MOV A<=ACC; XOR
      begin_test();
      set_reg(BUS_ACC, 8'h11); set_reg(BUS_TEMP, 8'h22);
      set_mem(8'h00, 8'h04); set_mem(8'h01, 8'h0E); set_mem(8'h02, 8'h01);
      e = mk("movxor", 14, 8'h03, 1'b0);
      e.chk_acc = 1'b1; e.acc = 8'h33;
      go(e);

      // JMP 05
      begin_test();
      set_mem(8'h00, 8'h18); set_mem(8'h01, 8'h05); set_mem(8'h05, 8'h01);
      go(mk("jmp", 11, 8'h06, 1'b0));

      // JZ with Z=1, operand 40
      begin_test();
      set_reg(BUS_A, 8'h07); set_reg(BUS_TEMP, 8'h07);
      set_mem(8'h00, 8'h0B); set_mem(8'h01, 8'h19); set_mem(8'h02, 8'h40);
      set_mem(8'h40, 8'h01);
`ifdef CTRL_COND_BRANCH_EN
      go(mk("jz_taken", 16, 8'h41, 1'b0));
`else
      go(mk("jz_undef", 9, 8'h02, 1'b1));
`endif

      // JZ with Z=0: skip operand
      begin_test();
      set_reg(BUS_A, 8'h05); set_reg(BUS_TEMP, 8'h03);
      set_mem(8'h00, 8'h0A); set_mem(8'h01, 8'h19); set_mem(8'h02, 8'h40);
      set_mem(8'h03, 8'h01);
`ifdef CTRL_COND_BRANCH_EN
      go(mk("jz_not_taken", 14, 8'h04, 1'b0));
`else
      go(mk("jz_undef2", 9, 8'h02, 1'b1));
`endif

      // Undefined opcode 1F
      begin_test();
      set_mem(8'h00, 8'h1F);
      go(mk("illegal_1f", 4, 8'h01, 1'b1));

      // rst asserted in LD M1 aborts at once
      begin_test();
      set_reg(BUS_DPTR, 8'h20);
      set_mem(8'h00, 8'h02);
      rst = 1'b0;
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      n = 0;
      while (state_dbg != ST_M1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (state_dbg != ST_M1) begin
         checks++;
         failures++;
         $display("FAIL rst_m1.reach: state %0d never reached M1", state_dbg);
      end
      rst = 1'b1;
      #1;
      check("rst_m1.state",      state_dbg,      ST_IDLE);
      check("rst_m1.halted",     halted,         1'b1);
      check("rst_m1.illegal",    illegal,        1'b0);
      check("rst_m1.bank_wr_en", bus.bank_wr_en, 1'b0);
      check("rst_m1.wr_rdn",     bus.wr_rdn,     1'b0);
      check("rst_m1.mdr_en",     bus.mdr_en,     1'b0);
      @(posedge clk);
      #1;
      check("rst_m1.state_next", state_dbg,      ST_IDLE);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
